// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth multiplier family:
// the FSM state encoding, the Booth operation codes and the iteration count.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WORK = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [2:0] OP_ZERO = 3'd0;
  localparam logic [2:0] OP_PM   = 3'd1;
  localparam logic [2:0] OP_P2M  = 3'd2;
  localparam logic [2:0] OP_NM   = 3'd3;
  localparam logic [2:0] OP_N2M  = 3'd4;

  // Two extension bits make the multiplier WIDTH+2 bits, i.e. WIDTH/2+1 digit groups.
  function automatic int booth_iters(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_radix4_encoder.sv
// Radix-4 Booth digit decoder: maps a 3-bit multiplier window to an operation code.
module booth_radix4_encoder
  import booth_pkg::*;
(
  input  logic [2:0] window,
  output logic [2:0] op
);

  always_comb begin
    op = OP_ZERO;
    case (window)
      3'b001, 3'b010: op = OP_PM;
      3'b011:         op = OP_P2M;
      3'b100:         op = OP_N2M;
      3'b101, 3'b110: op = OP_NM;
      default:        op = OP_ZERO;
    endcase
  end

endmodule

// File: rtl/booth_multiplier_param.sv
// Sequential radix-4 Booth multiplier, signed or unsigned per operation,
// with a busy/done handshake and a zero-operand early-out.
module booth_multiplier_param
  import booth_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH / 2 + 2)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 done,
  output logic                 busy
);

  localparam int N_ITER = booth_iters(WIDTH);
  localparam int AW     = 2 * WIDTH + 4;
  localparam int QW     = WIDTH + 3;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_ITER - 1);

  generate
    if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
      $error("booth_multiplier_param: WIDTH must be even and >= 4");
    end
  endgenerate

  state_t               state_reg;
  logic [AW-1:0]        acc_reg;
  logic [AW-1:0]        m_reg;
  logic [QW-1:0]        q_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [2*WIDTH-1:0]   product_reg;
  logic                 done_reg;

  logic [WIDTH+1:0]     m_ext;
  logic [WIDTH+1:0]     q_ext;
  logic [AW-1:0]        m_wide;
  logic                 operand_zero;
  logic [2:0]           op;
  logic [AW-1:0]        addend;
  logic                 carry_in;
  logic [AW-1:0]        sum;

  assign m_ext        = is_signed ? {{2{multiplicand[WIDTH-1]}}, multiplicand} : {2'b00, multiplicand};
  assign q_ext        = is_signed ? {{2{multiplier[WIDTH-1]}}, multiplier} : {2'b00, multiplier};
  assign m_wide       = {{(AW - WIDTH - 2){m_ext[WIDTH+1]}}, m_ext};
  assign operand_zero = (multiplicand == '0) || (multiplier == '0);

  booth_radix4_encoder u_encoder (
    .window (q_reg[2:0]),
    .op     (op)
  );

  // m_reg is pre-shifted by 4^count, so each term lands at its weight directly.
  always_comb begin
    addend   = '0;
    carry_in = 1'b0;
    case (op)
      OP_PM:   addend = m_reg;
      OP_P2M:  addend = m_reg << 1;
      OP_NM: begin
        addend   = ~m_reg;
        carry_in = 1'b1;
      end
      OP_N2M: begin
        addend   = ~(m_reg << 1);
        carry_in = 1'b1;
      end
      default: addend = '0;
    endcase
  end

  assign sum = acc_reg + addend + {{(AW - 1){1'b0}}, carry_in};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      acc_reg     <= '0;
      m_reg       <= '0;
      q_reg       <= '0;
      cnt_reg     <= '0;
      product_reg <= '0;
      done_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            m_reg     <= m_wide;
            q_reg     <= {q_ext, 1'b0};
            acc_reg   <= '0;
            cnt_reg   <= '0;
            state_reg <= operand_zero ? DONE : WORK;
          end
        end
        WORK: begin
          acc_reg <= sum;
          m_reg   <= m_reg << 2;
          q_reg   <= QW'($signed(q_reg) >>> 2);
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_CNT) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          product_reg <= acc_reg[2*WIDTH-1:0];
          done_reg    <= 1'b1;
          state_reg   <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign product = product_reg;
  assign done    = done_reg;
  assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_booth_multiplier_param.sv
// Directed and randomized checks of booth_multiplier_param at WIDTH=8 and WIDTH=16.
module tb_booth_multiplier_param;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        start8 = 1'b0, sg8 = 1'b0, done8, busy8;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] product8;

  logic        start16 = 1'b0, sg16 = 1'b0, done16, busy16;
  logic [15:0] a16 = '0, b16 = '0;
  logic [31:0] product16;

  int errors = 0;
  int checks = 0;

  booth_multiplier_param #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .is_signed(sg8),
    .multiplicand(a8), .multiplier(b8),
    .product(product8), .done(done8), .busy(busy8)
  );

  booth_multiplier_param #(.WIDTH(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .start(start16), .is_signed(sg16),
    .multiplicand(a16), .multiplier(b16),
    .product(product16), .done(done16), .busy(busy16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after an edge; the next edge is the start edge (edge 0).
  // lat is the number of edges after edge 0 until done is observed high.
  task automatic op8(input string tag, input logic sg, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] exp, input int lat);
    int n;
    sg8 = sg; a8 = a; b8 = b; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check({tag, "_busy"}, busy8, 1'b1);
    n = 0;
    while (!done8 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, n, lat);
    check({tag, "_prod"}, product8, exp);
    $display("op %s: %h*%h signed=%0d -> %h after %0d edges", tag, a, b, sg, product8, n);
    tick();
    check({tag, "_done_drop"}, done8, 1'b0);
    check({tag, "_idle"}, busy8, 1'b0);
  endtask

  task automatic op16(input string tag, input logic sg, input logic [15:0] a, input logic [15:0] b,
                      input logic [31:0] exp, input int lat, input bit verbose);
    int n;
    sg16 = sg; a16 = a; b16 = b; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    n = 0;
    while (!done16 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, n, lat);
    check({tag, "_prod"}, product16, exp);
    if (verbose)
      $display("op %s: %h*%h signed=%0d -> %h after %0d edges", tag, a, b, sg, product16, n);
    tick();
    check({tag, "_done_drop"}, done16, 1'b0);
  endtask

  initial begin
    int n, pulses, lat_seen;
    logic [15:0] prod_seen;
    logic [15:0] ra, rb;
    logic rs;
    longint ref_p;

    // Reset state
    tick(); tick();
    check("rst_prod8", product8, 16'h0);
    check("rst_done8", done8, 1'b0);
    check("rst_busy8", busy8, 1'b0);
    check("rst_prod16", product16, 32'h0);
    reset_n = 1'b1;
    tick();

    op8("neg_min_sq", 1'b1, 8'h80, 8'h80, 16'h4000, 6);
    op8("ff_x1_s",    1'b1, 8'hFF, 8'h01, 16'hFFFF, 6);
    op8("ff_x1_u",    1'b0, 8'hFF, 8'h01, 16'h00FF, 6);
    op8("ff_ff_u",    1'b0, 8'hFF, 8'hFF, 16'hFE01, 6);
    op8("ff_ff_s",    1'b1, 8'hFF, 8'hFF, 16'h0001, 6);
    op8("zero_op",    1'b1, 8'h00, 8'h7F, 16'h0000, 1);
    op8("seven_m3",   1'b1, 8'h07, 8'hFD, 16'hFFEB, 6);

    // Start re-pulsed while busy must be ignored
    sg8 = 1'b1; a8 = 8'd12; b8 = 8'd11; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    pulses = 0; lat_seen = 0; prod_seen = '0;
    for (int c = 1; c <= 16; c++) begin
      if (c == 1) begin a8 = 8'd5; b8 = 8'd5; start8 = 1'b1; end
      if (c == 3) start8 = 1'b0;
      tick();
      if (done8) begin
        pulses++;
        if (pulses == 1) begin lat_seen = c; prod_seen = product8; end
      end
    end
    check("repulse_count", pulses, 1);
    check("repulse_lat", lat_seen, 6);
    check("repulse_prod", prod_seen, 16'h0084);
    $display("op repulse: 12*11 with 5*5 re-pulse -> %h, %0d done pulses", prod_seen, pulses);

    // Asynchronous reset mid-operation
    sg8 = 1'b0; a8 = 8'd100; b8 = 8'd100; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    check("abort_busy_before", busy8, 1'b1);
    reset_n = 1'b0;
    #1;
    check("abort_busy", busy8, 1'b0);
    check("abort_done", done8, 1'b0);
    check("abort_prod", product8, 16'h0000);
    tick(); tick();
    check("abort_no_done", done8, 1'b0);
    reset_n = 1'b1;
    tick();
    $display("op abort: reset during 100*100 -> product %h", product8);
    op8("after_rst", 1'b0, 8'd3, 8'd4, 16'h000C, 6);

    // Start held high relaunches after one idle cycle with freshly captured operands
    sg8 = 1'b0; a8 = 8'd2; b8 = 8'd3; start8 = 1'b1;
    tick();
    n = 0;
    while (!done8 && n < 40) begin tick(); n++; end
    check("held_lat1", n, 6);
    check("held_prod1", product8, 16'h0006);
    check("held_gap", busy8, 1'b0);
    a8 = 8'd5;
    tick();
    check("held_relaunch", busy8, 1'b1);
    n = 0;
    while (!done8 && n < 40) begin tick(); n++; end
    start8 = 1'b0;
    check("held_lat2", n, 6);
    check("held_prod2", product8, 16'h000F);
    $display("op held: 2*3 then 5*3 back to back -> %h", product8);
    tick(); tick();

    // WIDTH=16
    op16("w16_umax", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 10, 1'b1);
    op16("w16_smix", 1'b1, 16'h8000, 16'h7FFF, 32'hC0008000, 10, 1'b1);
    op16("w16_smin", 1'b1, 16'h8000, 16'h8000, 32'h40000000, 10, 1'b1);

    for (int i = 0; i < 2000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 97 == 0) ra = 16'h8000;
      if (i % 89 == 0) rb = 16'hFFFF;
      rs = 1'($urandom_range(0, 1));
      if (rs) ref_p = longint'($signed(ra)) * longint'($signed(rb));
      else    ref_p = longint'(ra) * longint'(rb);
      op16($sformatf("rnd%0d", i), rs, ra, rb, ref_p[31:0],
           (ra == 16'h0 || rb == 16'h0) ? 1 : 10, 1'b0);
      $display("op rnd%0d: %h*%h signed=%0d -> %h", i, ra, rb, rs, product16);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
